// File: rtl/xoodyak_pkg.sv
// Shared constants and types for the single-block Xoodyak keyed AEAD engine.
// Holds the round constants, domain bytes, vector widths and FSM encoding.
package xoodyak_pkg;

  localparam int STATE = 384;
  localparam int TEXT  = 192;
  localparam int BLK   = 128;

  localparam logic [7:0] DOM_PAD     = 8'h01;
  localparam logic [7:0] DOM_KEY     = 8'h02;
  localparam logic [7:0] DOM_ABSORB  = 8'h03;
  localparam logic [7:0] DOM_CRYPT   = 8'h80;
  localparam logic [7:0] DOM_SQUEEZE = 8'h40;

  localparam logic [0:11][31:0] RC = {
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  typedef enum logic [0:0] {S_IDLE, S_PERM} fsm_e;

endpackage

// File: rtl/rregs.sv
// Plain D register without reset; any reset is folded into d by the caller.
module rregs #(
  parameter int DATA_W = 1
) (
  output logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] d,
  input  logic              clk
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
module xoodoo_round
  import xoodyak_pkg::*;
(
  input  logic [STATE-1:0] state_in,
  input  logic [3:0]       rnd,
  output logic [STATE-1:0] state_out
);

  logic [31:0] a [3][4];
  logic [31:0] p [4];
  logic [31:0] e [4];
  logic [31:0] b [3][4];
  logic [31:0] c [3][4];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  always_comb begin
    state_out = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        a[y][x] = state_in[32*(x+4*y) +: 32];
    for (int x = 0; x < 4; x++)
      p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    for (int x = 0; x < 4; x++)
      e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    // theta folded into rho-west, iota on lane (0,0)
    for (int x = 0; x < 4; x++) begin
      b[0][x] = a[0][x] ^ e[x] ^ ((x == 0) ? RC[rnd] : 32'h0);
      b[1][x] = a[1][(x+3)%4] ^ e[(x+3)%4];
      b[2][x] = rotl(a[2][x] ^ e[x], 11);
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        c[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
    for (int x = 0; x < 4; x++) begin
      state_out[32*x      +: 32] = c[0][x];
      state_out[32*(x+4)  +: 32] = rotl(c[1][x], 1);
      state_out[32*(x+8)  +: 32] = rotl(c[2][(x+2)%4], 8);
    end
  end

endmodule

// File: rtl/xoodyak_aead.sv
// Single-block Xoodyak AEAD: four 12-round permutations, one round per clock,
// with the per-phase injection applied on the edge that completes round 11.
module xoodyak_aead
  import xoodyak_pkg::*;
(
  input  logic              eph1,
  input  logic              reset,
  input  logic              start,
  input  logic [TEXT-1:0]   textin,
  input  logic [BLK-1:0]    nonce,
  input  logic [BLK-1:0]    assodata,
  input  logic [BLK-1:0]    key,
  input  logic [BLK-1:0]    verification_data,
  input  logic              opmode,
  output logic [BLK-1:0]    authdata,
  output logic [TEXT-1:0]   textout,
  output logic              encdone,
  output logic              sqzdone,
  output logic              verify
);

  fsm_e             fsm, fsm_d;
  logic [0:0]       fsm_raw;
  logic [1:0]       phase, phase_d;
  logic [3:0]       rnd, rnd_d;
  logic [STATE-1:0] st, st_d, round_out, inj;
  logic [TEXT-1:0]  txt_q, txt_d, ct, pt, textout_d;
  logic [BLK-1:0]   non_q, non_d, ad_q, ad_d, vd_q, vd_d, authdata_d;
  logic             mode_q, mode_d, encdone_d, sqzdone_d, verify_d;

  assign fsm = fsm_e'(fsm_raw);

  rregs #(.DATA_W(1))     u_fsm   (.q(fsm_raw),  .d(fsm_d),      .clk(eph1));
  rregs #(.DATA_W(2))     u_phase (.q(phase),    .d(phase_d),    .clk(eph1));
  rregs #(.DATA_W(4))     u_rnd   (.q(rnd),      .d(rnd_d),      .clk(eph1));
  rregs #(.DATA_W(STATE)) u_st    (.q(st),       .d(st_d),       .clk(eph1));
  rregs #(.DATA_W(TEXT))  u_txt   (.q(txt_q),    .d(txt_d),      .clk(eph1));
  rregs #(.DATA_W(BLK))   u_non   (.q(non_q),    .d(non_d),      .clk(eph1));
  rregs #(.DATA_W(BLK))   u_ad    (.q(ad_q),     .d(ad_d),       .clk(eph1));
  rregs #(.DATA_W(BLK))   u_vd    (.q(vd_q),     .d(vd_d),       .clk(eph1));
  rregs #(.DATA_W(1))     u_mode  (.q(mode_q),   .d(mode_d),     .clk(eph1));
  rregs #(.DATA_W(TEXT))  u_tout  (.q(textout),  .d(textout_d),  .clk(eph1));
  rregs #(.DATA_W(BLK))   u_auth  (.q(authdata), .d(authdata_d), .clk(eph1));
  rregs #(.DATA_W(1))     u_encd  (.q(encdone),  .d(encdone_d),  .clk(eph1));
  rregs #(.DATA_W(1))     u_sqzd  (.q(sqzdone),  .d(sqzdone_d),  .clk(eph1));
  rregs #(.DATA_W(1))     u_ver   (.q(verify),   .d(verify_d),   .clk(eph1));

  xoodoo_round u_round (
    .state_in  (st),
    .rnd       (rnd),
    .state_out (round_out)
  );

  // Byte 16/24 carry the 0x01 pad, byte 47 carries the domain byte.
  always_comb begin
    ct  = round_out[TEXT-1:0] ^ txt_q;
    pt  = mode_q ? ct : txt_q;
    inj = round_out;
    case (phase)
      2'd0: begin
        inj[BLK-1:0]  ^= non_q;
        inj[135:128]  ^= DOM_PAD;
        inj[383:376]  ^= DOM_ABSORB;
      end
      2'd1: begin
        inj[BLK-1:0]  ^= ad_q;
        inj[135:128]  ^= DOM_PAD;
        inj[383:376]  ^= DOM_ABSORB ^ DOM_CRYPT;
      end
      2'd2: begin
        inj[TEXT-1:0] ^= pt;
        inj[199:192]  ^= DOM_PAD;
        inj[383:376]  ^= DOM_SQUEEZE;
      end
      default: ;
    endcase
  end

  always_comb begin
    fsm_d      = fsm;
    phase_d    = phase;
    rnd_d      = rnd;
    st_d       = st;
    txt_d      = txt_q;
    non_d      = non_q;
    ad_d       = ad_q;
    vd_d       = vd_q;
    mode_d     = mode_q;
    textout_d  = textout;
    authdata_d = authdata;
    encdone_d  = 1'b0;
    sqzdone_d  = 1'b0;
    verify_d   = verify;
    case (fsm)
      S_IDLE: begin
        if (start) begin
          fsm_d   = S_PERM;
          phase_d = 2'd0;
          rnd_d   = 4'd0;
          st_d    = {DOM_KEY, 232'b0, DOM_PAD, 8'h00, key};
          txt_d   = textin;
          non_d   = nonce;
          ad_d    = assodata;
          vd_d    = verification_data;
          mode_d  = opmode;
        end
      end
      default: begin
        st_d  = round_out;
        rnd_d = rnd + 4'd1;
        if (rnd == 4'd11) begin
          st_d    = inj;
          rnd_d   = 4'd0;
          phase_d = phase + 2'd1;
          if (phase == 2'd2) begin
            textout_d = ct;
            encdone_d = 1'b1;
          end
          if (phase == 2'd3) begin
            authdata_d = round_out[BLK-1:0];
            verify_d   = mode_q & (round_out[BLK-1:0] == vd_q);
            sqzdone_d  = 1'b1;
            fsm_d      = S_IDLE;
          end
        end
      end
    endcase
    if (reset) begin
      fsm_d      = S_IDLE;
      phase_d    = 2'd0;
      rnd_d      = 4'd0;
      textout_d  = '0;
      authdata_d = '0;
      encdone_d  = 1'b0;
      sqzdone_d  = 1'b0;
      verify_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_xoodyak_aead.sv
// Scoreboard bench for xoodyak_aead: a lane-array Xoodyak model predicts each
// accepted operation; results are compared when sqzdone fires.
module tb_xoodyak_aead;

  logic         eph1 = 1'b0;
  logic         reset, start, opmode;
  logic [191:0] textin;
  logic [127:0] nonce, assodata, key, verification_data;
  logic [127:0] authdata;
  logic [191:0] textout;
  logic         encdone, sqzdone, verify;

  always #5 eph1 = ~eph1;

  xoodyak_aead dut (
    .eph1(eph1), .reset(reset), .start(start), .textin(textin),
    .nonce(nonce), .assodata(assodata), .key(key),
    .verification_data(verification_data), .opmode(opmode),
    .authdata(authdata), .textout(textout), .encdone(encdone),
    .sqzdone(sqzdone), .verify(verify)
  );

  typedef struct packed {
    logic [191:0] text;
    logic [127:0] tag;
    logic         ver;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [127:0] K  = 128'h38393a3b3c3d3e3f3031323334353637;
  localparam logic [127:0] N  = 128'h494a4b4c4d4e4f504142434445464748;
  localparam logic [127:0] AD = 128'h696a6b6c6d6e6f706162636465666768;
  localparam logic [191:0] PT = 192'h4d4e4f5051525354555657584142434445464748494a4b4c;

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [383:0] xoodoo(input logic [383:0] s);
    logic [31:0] w [12];
    logic [31:0] t [12];
    logic [31:0] p [4];
    logic [31:0] rc [12];
    logic [383:0] r;
    rc = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
           32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};
    for (int i = 0; i < 12; i++) w[i] = s[32*i +: 32];
    for (int r2 = 0; r2 < 12; r2++) begin
      for (int x = 0; x < 4; x++) p[x] = w[x] ^ w[x+4] ^ w[x+8];
      for (int i = 0; i < 12; i++)
        w[i] = w[i] ^ rl(p[(i+3)%4], 5) ^ rl(p[(i+3)%4], 14);
      for (int x = 0; x < 4; x++) begin
        t[x]   = w[x];
        t[4+x] = w[4+(x+3)%4];
        t[8+x] = rl(w[8+x], 11);
      end
      t[0] = t[0] ^ rc[r2];
      for (int x = 0; x < 4; x++) begin
        w[x]   = t[x]   ^ (~t[4+x] & t[8+x]);
        w[4+x] = t[4+x] ^ (~t[8+x] & t[x]);
        w[8+x] = t[8+x] ^ (~t[x]   & t[4+x]);
      end
      for (int x = 0; x < 4; x++) begin
        t[x]   = w[x];
        t[4+x] = rl(w[4+x], 1);
        t[8+x] = rl(w[8+(x+2)%4], 8);
      end
      for (int i = 0; i < 12; i++) w[i] = t[i];
    end
    for (int i = 0; i < 12; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic exp_t model(input logic [127:0] k, input logic [127:0] n,
                                 input logic [127:0] a, input logic [191:0] tx,
                                 input logic [127:0] vd, input logic m);
    logic [383:0] s;
    logic [191:0] ptx;
    exp_t r;
    s = '0;
    s[127:0] = k;  s[143:136] = 8'h01;  s[383:376] = 8'h02;
    s = xoodoo(s);
    s[127:0] ^= n; s[135:128] ^= 8'h01; s[383:376] ^= 8'h03;
    s = xoodoo(s);
    s[127:0] ^= a; s[135:128] ^= 8'h01; s[383:376] ^= 8'h83;
    s = xoodoo(s);
    r.text = s[191:0] ^ tx;
    ptx = m ? r.text : tx;
    s[191:0] ^= ptx; s[199:192] ^= 8'h01; s[383:376] ^= 8'h40;
    s = xoodoo(s);
    r.tag = s[127:0];
    r.ver = m & (r.tag == vd);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one start cycle; inputs are scrambled afterwards to expose any
  // dependence on uncaptured inputs.
  task automatic issue(input logic [127:0] k, input logic [127:0] n,
                       input logic [127:0] a, input logic [191:0] tx,
                       input logic [127:0] vd, input logic m, input bit track);
    key = k; nonce = n; assodata = a; textin = tx;
    verification_data = vd; opmode = m; start = 1'b1;
    if (track) sb.push_back(model(k, n, a, tx, vd, m));
    @(posedge eph1); #1;
    start = 1'b0;
    key = ~k; nonce = ~n; assodata = ~a; textin = ~tx;
    verification_data = ~vd; opmode = ~m;
  endtask

  task automatic wait_done(input int c0, output int enc_c, output int sqz_c,
                           output logic [191:0] txo, output logic [127:0] tg,
                           output logic v, output bit ok);
    enc_c = -1; sqz_c = -1; txo = '0; tg = '0; v = 1'b0; ok = 1'b0;
    for (int c = c0 + 1; c <= c0 + 80 && !ok; c++) begin
      @(posedge eph1); #1;
      if (encdone === 1'b1) begin enc_c = c; txo = textout; end
      if (sqzdone === 1'b1) begin sqz_c = c; tg = authdata; v = verify; ok = 1'b1; end
    end
  endtask

  task automatic test_reset();
    int act;
    reset = 1'b1; start = 1'b0; opmode = 1'b0;
    key = '0; nonce = '0; assodata = '0; textin = '0; verification_data = '0;
    repeat (2) begin @(posedge eph1); #1; end
    tests++; if (textout !== '0) begin fails++; $display("FAIL rst_textout: got %h expected 0", textout); end
    tests++; if (authdata !== '0) begin fails++; $display("FAIL rst_authdata: got %h expected 0", authdata); end
    tests++; if (encdone !== 1'b0) begin fails++; $display("FAIL rst_encdone: got %b expected 0", encdone); end
    tests++; if (sqzdone !== 1'b0) begin fails++; $display("FAIL rst_sqzdone: got %b expected 0", sqzdone); end
    tests++; if (verify !== 1'b0) begin fails++; $display("FAIL rst_verify: got %b expected 0", verify); end
    issue(K, N, AD, PT, '0, 1'b0, 1'b0);
    @(posedge eph1); #1;
    reset = 1'b0;
    act = 0;
    repeat (60) begin @(posedge eph1); #1; if (encdone !== 1'b0 || sqzdone !== 1'b0) act++; end
    tests++; if (act !== 0) begin fails++; $display("FAIL rst_start_ignored: got %0d done pulses expected 0", act); end
    tests++; if (textout !== '0) begin fails++; $display("FAIL rst_start_textout: got %h expected 0", textout); end
  endtask

  task automatic test_encrypt();
    int ec, sc; logic [191:0] to; logic [127:0] tg; logic v; bit ok; exp_t e;
    issue(K, N, AD, PT, '0, 1'b0, 1'b1);
    wait_done(0, ec, sc, to, tg, v, ok);
    e = sb.pop_front();
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL enc_timeout: sqzdone seen %b expected 1", ok); end
    tests++; if (ec !== 36) begin fails++; $display("FAIL enc_encdone_cycle: got %0d expected 36", ec); end
    tests++; if (sc !== 48) begin fails++; $display("FAIL enc_sqzdone_cycle: got %0d expected 48", sc); end
    tests++; if (to !== e.text) begin fails++; $display("FAIL enc_text: got %h expected %h", to, e.text); end
    tests++; if (tg !== e.tag) begin fails++; $display("FAIL enc_tag: got %h expected %h", tg, e.tag); end
    tests++; if (v !== e.ver) begin fails++; $display("FAIL enc_verify: got %b expected %b", v, e.ver); end
  endtask

  task automatic test_back_to_back();
    int ec, sc; logic [191:0] to, ptx; logic [127:0] tg, k, n, a; logic v; bit ok; exp_t e;
    k = rnd128(); n = rnd128(); a = rnd128(); ptx = {rnd128(), 64'h0123456789abcdef};
    issue(k, n, a, ptx, '0, 1'b0, 1'b1);
    wait_done(0, ec, sc, to, tg, v, ok);
    e = sb.pop_front();
    tests++; if (to !== e.text) begin fails++; $display("FAIL b2b_enc_text: got %h expected %h", to, e.text); end
    tests++; if (tg !== e.tag) begin fails++; $display("FAIL b2b_enc_tag: got %h expected %h", tg, e.tag); end
    // issued in the sqzdone cycle of the encrypt
    issue(k, n, a, to, tg, 1'b1, 1'b1);
    wait_done(0, ec, sc, to, tg, v, ok);
    tests++; if (sc !== 48) begin fails++; $display("FAIL b2b_dec_sqzdone_cycle: got %0d expected 48", sc); end
    tests++; if (to !== ptx) begin fails++; $display("FAIL b2b_dec_plain: got %h expected %h", to, ptx); end
    tests++; if (tg !== e.tag) begin fails++; $display("FAIL b2b_dec_tag: got %h expected %h", tg, e.tag); end
    e = sb.pop_front();
    tests++; if (to !== e.text) begin fails++; $display("FAIL b2b_dec_model: got %h expected %h", to, e.text); end
    tests++; if (v !== 1'b1) begin fails++; $display("FAIL b2b_verify: got %b expected 1", v); end
  endtask

  task automatic test_tag_flip();
    int ec, sc; logic [191:0] to; logic [127:0] tg; logic v; bit ok; exp_t e0, e;
    e0 = model(K, N, AD, PT, '0, 1'b0);
    issue(K, N, AD, e0.text, e0.tag ^ (128'h1 << 37), 1'b1, 1'b1);
    wait_done(0, ec, sc, to, tg, v, ok);
    e = sb.pop_front();
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL flip_verify: got %b expected 0", v); end
    tests++; if (to !== PT) begin fails++; $display("FAIL flip_plain: got %h expected %h", to, PT); end
    tests++; if (tg !== e.tag) begin fails++; $display("FAIL flip_tag: got %h expected %h", tg, e.tag); end
  endtask

  task automatic test_restart_ignored();
    int ec, sc; logic [191:0] to; logic [127:0] tg; logic v; bit ok; exp_t e;
    issue(K ^ 128'h5a, N, AD, PT, '0, 1'b0, 1'b1);
    repeat (19) begin @(posedge eph1); #1; end
    issue(rnd128(), rnd128(), rnd128(), ~PT, rnd128(), 1'b1, 1'b0);
    wait_done(20, ec, sc, to, tg, v, ok);
    e = sb.pop_front();
    tests++; if (ec !== 36) begin fails++; $display("FAIL restart_encdone_cycle: got %0d expected 36", ec); end
    tests++; if (sc !== 48) begin fails++; $display("FAIL restart_sqzdone_cycle: got %0d expected 48", sc); end
    tests++; if (to !== e.text) begin fails++; $display("FAIL restart_text: got %h expected %h", to, e.text); end
    tests++; if (tg !== e.tag) begin fails++; $display("FAIL restart_tag: got %h expected %h", tg, e.tag); end
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL restart_verify: got %b expected 0", v); end
  endtask

  task automatic test_reset_midop();
    int ec, sc, act; logic [191:0] to; logic [127:0] tg; logic v; bit ok; exp_t e;
    issue(rnd128(), N, AD, PT, '0, 1'b0, 1'b1);
    repeat (29) begin @(posedge eph1); #1; end
    reset = 1'b1;
    @(posedge eph1); #1;
    reset = 1'b0;
    e = sb.pop_back();
    tests++; if (textout !== '0) begin fails++; $display("FAIL midrst_textout: got %h expected 0", textout); end
    tests++; if (authdata !== '0) begin fails++; $display("FAIL midrst_authdata: got %h expected 0", authdata); end
    tests++; if (verify !== 1'b0) begin fails++; $display("FAIL midrst_verify: got %b expected 0", verify); end
    act = 0;
    repeat (40) begin @(posedge eph1); #1; if (encdone !== 1'b0 || sqzdone !== 1'b0) act++; end
    tests++; if (act !== 0) begin fails++; $display("FAIL midrst_quiet: got %0d done pulses expected 0", act); end
    issue(K, N ^ 128'h1, AD, PT, '0, 1'b0, 1'b1);
    wait_done(0, ec, sc, to, tg, v, ok);
    e = sb.pop_front();
    tests++; if (sc !== 48) begin fails++; $display("FAIL midrst_next_cycle: got %0d expected 48", sc); end
    tests++; if (to !== e.text) begin fails++; $display("FAIL midrst_next_text: got %h expected %h", to, e.text); end
    tests++; if (tg !== e.tag) begin fails++; $display("FAIL midrst_next_tag: got %h expected %h", tg, e.tag); end
  endtask

  task automatic test_random();
    int ec, sc; logic [191:0] to; logic [127:0] tg; logic v; bit ok; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(rnd128(), rnd128(), rnd128(), {rnd128(), rnd128()} >> 64 | {rnd128(), 64'h0},
            rnd128(), 1'(i % 2), 1'b1);
      wait_done(0, ec, sc, to, tg, v, ok);
      e = sb.pop_front();
      tests++; if (to !== e.text) begin fails++; $display("FAIL rand%0d_text: got %h expected %h", i, to, e.text); end
      tests++; if (tg !== e.tag) begin fails++; $display("FAIL rand%0d_tag: got %h expected %h", i, tg, e.tag); end
      tests++; if (v !== e.ver) begin fails++; $display("FAIL rand%0d_verify: got %b expected %b", i, v, e.ver); end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back();
    test_tag_flip();
    test_restart_ignored();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xoodyak_aead.md
# xoodyak_aead

Single-block Xoodyak keyed-mode AEAD engine: absorbs a 128-bit key, a 128-bit nonce and 128-bit associated data, then encrypts or decrypts 192 bits of text and squeezes a 128-bit tag. It is built around a 384-bit Xoodoo state with one round per clock. It sits between the host interface and the tag-check logic; encrypt and decrypt instances may be chained back to back.

## Interface
- No parameters.
- eph1 in 1: clock; all flops update on rising edge.
- reset in 1: synchronous, active-high.
- start in 1: one-cycle request; all data inputs and opmode are captured on this edge.
- textin in 192: plaintext (opmode=0) or ciphertext (opmode=1).
- nonce in 128: nonce.
- assodata in 128: associated data.
- key in 128: key.
- verification_data in 128: expected tag (decrypt only).
- opmode in 1: 0 = encrypt, 1 = decrypt.
- authdata out 128: squeezed tag.
- textout out 192: ciphertext (encrypt) or plaintext (decrypt).
- encdone out 1: one-cycle pulse when textout becomes valid.
- sqzdone out 1: one-cycle pulse when authdata becomes valid.
- verify out 1: 1 iff opmode=1 and the computed tag equals verification_data.

## Operation
- Byte i of any vector is bits [8i+7:8i]. State word w (w = 0..11) is bytes 4w..4w+3, little-endian. Lane (x,y) is word x+4y, plane y = 0..2.
- Xoodoo round:
  - theta: P = A0^A1^A2; E = rot(P shifted x+1, z<<<5) ^ rot(P shifted x+1, z<<<14); Ay ^= E.
  - rho-west: A1 lanes x→x+1; A2 z<<<11.
  - iota: lane(0,0) ^= RC[r].
  - chi: Ay ^= ~A(y+1) & A(y+2).
  - rho-east: A1 z<<<1; A2 lanes x→x+2, z<<<8.
- RC[0..11] = 058, 038, 3C0, 0D0, 120, 014, 060, 02C, 380, 0F0, 1A0, 012 (hex). One permutation = 12 rounds.
- On accepted start (IDLE, reset low), the state is loaded with K || 0x00 || 0x01 || zeros, with byte 47 = 0x02.
- After P1: state ^= N || 0x01, byte 47 ^= 0x03.
- After P2: state ^= AD || 0x01, byte 47 ^= 0x03 ^ 0x80.
- After P3, let O = state bytes 0..23:
  - textout = O ^ textin.
  - Plaintext Pt = textin (encrypt) or textout (decrypt).
  - state ^= Pt || 0x01, byte 47 ^= 0x40.
- After P4: authdata = state bytes 0..15; verify = opmode & (authdata == verification_data).
- FSM: IDLE → PERM(phase 0..3, round 0..11) → IDLE. The injection after each phase is XORed onto the round output in the same edge as round 11.
- start while busy: ignored. Captured inputs do not change mid-operation.
- textout, authdata and verify hold until overwritten by the next operation or by reset.

## Timing
- Edge E0 accepts start. Permutation k occupies edges 12(k-1)+1 .. 12k.
- textout is registered at E36. encdone is high for the cycle following E36.
- authdata and verify are registered at E48. sqzdone is high for the cycle following E48.
- A new start is accepted in the sqzdone cycle, giving a 49-cycle issue interval.
- Reset: all outputs are 0 and the FSM returns to IDLE on the next edge, including mid-operation. start is ignored while reset is high.
- A decrypt instance started by sqzdone of an encrypt instance, fed textout through one register stage and authdata directly, sees stable data.

## Structure
- Package xoodyak_pkg holds:
  - RC array and domain constants (0x01 pad, 0x02 key, 0x03 absorb, 0x80 crypt, 0x40 squeeze).
  - Width localparams (STATE=384, TEXT=192, BLK=128).
  - FSM state enum.
- Sub-module xoodoo_round: combinational, 384-bit in, 4-bit round index, 384-bit out.
- Registers use the codebase rregs primitive (q, d, clk).

## Test plan
- Reset held 2 cycles → authdata=0, textout=0, encdone=sqzdone=verify=0. Pulse start while reset is high → no activity.
- Encrypt:
  - Inputs: key 38393a3b3c3d3e3f3031323334353637, nonce 494a4b4c4d4e4f504142434445464748, AD 696a6b6c6d6e6f706162636465666768, text 4d4e…4b4c.
  - Required: encdone exactly 36 cycles and sqzdone exactly 48 cycles after the start edge.
  - textout and authdata must bit-match the Xoodyak reference C model.
- Chained decrypt (start=sqzdone, textin=registered textout, verification_data=authdata) → dec textout = original plaintext, dec authdata = enc authdata, verify=1.
- Decrypt with one tag bit flipped → verify=0. Decrypted text is still produced.
- start re-pulsed at cycle 20 of an operation → ignored; outputs are identical to an undisturbed run.
- Reset asserted at cycle 30 → outputs cleared, no encdone. The next start produces a correct result.
